// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the fetch FSM encoding, special instruction words and primary opcodes.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hA800_FFFF;  // JMP -1: branch to itself
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // Primary 6-bit opcodes, bits [31:26] of the instruction word.
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_LD  = 6'b100100;
  localparam logic [5:0] OP_ST  = 6'b100101;
  localparam logic [5:0] OP_BEZ = 6'b101000;
  localparam logic [5:0] OP_BNE = 6'b101001;
  localparam logic [5:0] OP_JMP = 6'b101010;

  function automatic logic [5:0] opcode_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  // Only the exact self-jump encoding stops fetch; other JMPs are ordinary.
  function automatic logic is_halt(input logic [31:0] inst);
    return (opcode_of(inst) == OP_JMP) && (inst == HALT_WORD);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures PC+4 and the fetched word.
// flush has priority over en and loads a NOP bubble with valid cleared.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_next,
  input  logic [31:0] inst_next,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      inst  <= NOP;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= RESET_PC;
      inst  <= NOP;
      valid <= 1'b0;
    end else if (en) begin
      pc    <= pc_next;
      inst  <= inst_next;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control FSM,
// delivered-instruction counter and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic [31:0] inst_adrs,
  input  logic [31:0] inst_in,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [15:0]  cnt;
  logic         ifid_en;
  logic         ifid_flush;

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 becomes 0.
  assign pc_plus4 = pc + PC_STEP;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (br_taken)     ifid_flush = 1'b1;
        else if (!freeze) ifid_en    = 1'b1;
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (br_taken) begin
            pc <= {br_addr[31:2], 2'b00};
          end else if (!freeze) begin
            pc <= pc_plus4;
            if (cnt != CNT_MAX) cnt <= cnt + 16'd1;
            // The halt word itself is still delivered on this edge.
            if (is_halt(inst_in)) state <= ST_HALT;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst),
    .en        (ifid_en),
    .flush     (ifid_flush),
    .pc_next   (pc_plus4),
    .inst_next (inst_in),
    .pc        (if_id_pc),
    .inst      (if_id_inst),
    .valid     (if_id_valid)
  );

  assign inst_adrs = pc;
  assign halted    = (state == ST_HALT);
  assign fetch_cnt = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational memory
// model returning word = address, plus an optional halt word at 0x190.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [31:0] inst_adrs;
  logic [31:0] inst_in;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic        halt_en;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .inst_adrs   (inst_adrs),
    .inst_in     (inst_in),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  assign inst_in = (halt_en && inst_adrs == 32'h0000_0190) ? 32'hA800_FFFF : inst_adrs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                            input logic [31:0] inst, input logic v, input logic [15:0] cnt,
                            input logic h);
    check({tag, ".inst_adrs"},   inst_adrs, pc);
    check({tag, ".if_id_pc"},    if_id_pc, ipc);
    check({tag, ".if_id_inst"},  if_id_inst, inst);
    check({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    check({tag, ".fetch_cnt"},   {16'b0, fetch_cnt}, {16'b0, cnt});
    check({tag, ".halted"},      {31'b0, halted}, {31'b0, h});
  endtask

  initial begin
    int guard;
    rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_addr = '0; halt_en = 1'b0;
    #1;
    expect_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
    step();
    rst = 1'b1;
    check("boot.pc", inst_adrs, 32'h0);

    // Straight-line fetch from 0
    step(); expect_all("boot_edge", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
    step(); expect_all("run1", 32'h4, 32'h4, 32'h0, 1'b1, 16'd1, 1'b0);
    step(); expect_all("run2", 32'h8, 32'h8, 32'h4, 1'b1, 16'd2, 1'b0);
    step(); expect_all("run3", 32'hC, 32'hC, 32'h8, 1'b1, 16'd3, 1'b0);
    step(); expect_all("run4", 32'h10, 32'h10, 32'hC, 1'b1, 16'd4, 1'b0);

    // Freeze two cycles at 0x10
    freeze = 1'b1;
    step(); expect_all("frz1", 32'h10, 32'h10, 32'hC, 1'b1, 16'd4, 1'b0);
    step(); expect_all("frz2", 32'h10, 32'h10, 32'hC, 1'b1, 16'd4, 1'b0);
    freeze = 1'b0;
    step(); expect_all("resume", 32'h14, 32'h14, 32'h10, 1'b1, 16'd5, 1'b0);
    step(); step(); step();
    expect_all("at20", 32'h20, 32'h20, 32'h1C, 1'b1, 16'd8, 1'b0);

    // Branch overrides freeze, target alignment forced
    br_taken = 1'b1; freeze = 1'b1; br_addr = 32'h57;
    step();
    check("br.pc", inst_adrs, 32'h54);
    check("br.valid", {31'b0, if_id_valid}, 32'h0);
    check("br.inst", if_id_inst, 32'h0);
    check("br.cnt", {16'b0, fetch_cnt}, 32'd8);
    freeze = 1'b0; br_addr = 32'h188;
    step();
    check("br2.pc", inst_adrs, 32'h188);
    br_taken = 1'b0; halt_en = 1'b1;
    step(); expect_all("pre_halt1", 32'h18C, 32'h18C, 32'h188, 1'b1, 16'd9, 1'b0);
    step(); expect_all("pre_halt2", 32'h190, 32'h190, 32'h18C, 1'b1, 16'd10, 1'b0);
    step(); expect_all("halt_edge", 32'h194, 32'h194, 32'hA800FFFF, 1'b1, 16'd11, 1'b1);
    br_taken = 1'b1; br_addr = 32'h40; freeze = 1'b1;
    step();
    check("halt.pc", inst_adrs, 32'h194);
    check("halt.valid", {31'b0, if_id_valid}, 32'h0);
    check("halt.inst", if_id_inst, 32'h0);
    check("halt.cnt", {16'b0, fetch_cnt}, 32'd11);
    check("halt.halted", {31'b0, halted}, 32'h1);
    step();
    check("halt2.pc", inst_adrs, 32'h194);
    br_taken = 1'b0; freeze = 1'b0;

    // Asynchronous reset mid-cycle while halted
    #3 rst = 1'b0;
    #1 expect_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
    #1 rst = 1'b1;
    step(); expect_all("reboot", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 1'b0);
    step(); expect_all("refetch", 32'h4, 32'h4, 32'h0, 1'b1, 16'd1, 1'b0);

    // Drive the counter to saturation, then wrap the PC
    halt_en = 1'b0;
    guard = 0;
    while (fetch_cnt != 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    check("sat.reach", {16'b0, fetch_cnt}, 32'h0000FFFF);
    check("sat.cycles", guard, 32'd65534);
    br_taken = 1'b1; br_addr = 32'hFFFF_FFFF;
    step();
    check("wrap.pc_pre", inst_adrs, 32'hFFFF_FFFC);
    br_taken = 1'b0;
    step(); expect_all("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 16'hFFFF, 1'b0);
    step(); expect_all("sat_hold", 32'h4, 32'h4, 32'h0, 1'b1, 16'hFFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL use a single clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  in  1  clock, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: freeze  in  1  hazard stall from hazard unit; hold PC and IF/ID.
REQ-005 SHALL have port: br_taken  in  1  taken branch or jump resolved in ID.
REQ-006 SHALL have port: br_addr  in  32  byte target address for br_taken.
REQ-007 SHALL have port: inst_adrs  out  32  byte address to instruction memory; equals PC.
REQ-008 SHALL have port: inst_in  in  32  combinational instruction word returned for inst_adrs.
REQ-009 SHALL have port: if_id_pc  out  32  registered PC+4 of the captured instruction.
REQ-010 SHALL have port: if_id_inst  out  32  registered instruction; 0 (NOP) when invalid.
REQ-011 SHALL have port: if_id_valid  out  1  registered, 1 when if_id_inst is a real fetch.
REQ-012 SHALL have port: halted  out  1  1 while FSM is in HALT.
REQ-013 SHALL have port: fetch_cnt  out  16  count of instructions delivered to ID.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, HALT; BOOT->RUN unconditionally on the first edge after reset release.
REQ-015 In BOOT, SHALL hold PC at 0 and load IF/ID with NOP, valid 0.
REQ-016 In RUN with br_taken=1, SHALL load PC<=br_addr with bits[1:0] forced 0 and IF/ID<=NOP, valid 0; br_taken overrides freeze.
REQ-017 In RUN with br_taken=0 and freeze=1, SHALL hold PC, IF/ID and fetch_cnt unchanged.
REQ-018 In RUN with br_taken=0 and freeze=0, SHALL set PC<=PC+4, if_id_pc<=PC+4, if_id_inst<=inst_in, if_id_valid<=1, fetch_cnt+1.
REQ-019 PC+4 SHALL wrap modulo 2^32, 0xFFFFFFFC -> 0x00000000.
REQ-020 fetch_cnt SHALL saturate at 0xFFFF.
REQ-021 RUN->HALT SHALL occur on the edge where REQ-018 captures inst_in == 0xA800FFFF (JMP -1); that word is still delivered with valid 1.
REQ-022 In HALT, SHALL hold PC and fetch_cnt, ignore freeze and br_taken, and load IF/ID with NOP, valid 0, from the next edge onward; only reset exits HALT.
REQ-023 Fetch latency SHALL be one cycle: the word at inst_adrs in cycle N appears on if_id_inst after edge N+1.
REQ-024 inst_adrs SHALL be driven directly from the PC register with no combinational path from any input.

Reset
REQ-025 rst=0 SHALL asynchronously force state BOOT, PC=0, if_id_pc=0, if_id_inst=0, if_id_valid=0, fetch_cnt=0, halted=0.
REQ-026 Reset asserted mid-operation, including during freeze or HALT, SHALL discard all state; fetch restarts at address 0.

Structure
REQ-027 Shared package SHALL hold the FSM state typedef, NOP=32'h0, HALT_WORD=32'hA800FFFF, RESET_PC=32'h0 and the 6-bit opcode constants.
REQ-028 The IF/ID register SHALL be a sub-module named if_id_reg, with enable, flush and async active-low reset; the PC, FSM and counter stay in fetch_stage.

Verification
REQ-029 Scenario: reset, then 5 cycles with no freeze or branch, memory word = address -> inst_adrs 0,0,4,8,12; if_id_pc 4,8,12; fetch_cnt 3.
REQ-030 Scenario: freeze=1 for 2 cycles at PC=0x10 -> inst_adrs stays 0x10; IF/ID and fetch_cnt unchanged; resume at 0x14.
REQ-031 Scenario: br_taken=1, freeze=1, br_addr=0x57 at PC=0x20 -> next PC 0x54, if_id_valid 0, if_id_inst 0.
REQ-032 Scenario: memory returns 0xA800FFFF at 0x190 -> word delivered valid once, halted=1, PC held, later br_taken ignored.
REQ-033 Scenario: PC=0xFFFFFFFC, no stall -> PC wraps to 0; with fetch_cnt preset at 0xFFFF it stays 0xFFFF.
REQ-034 Scenario: rst pulsed low mid-clock during HALT -> outputs zero immediately without a clock edge; BOOT then fetch from 0.
